// File: rtl/rtc_seq_pkg.sv
// rtc_seq_pkg: state encodings, step tables and reset constants for rtc_seq_engine.
package rtc_seq_pkg;

  localparam int unsigned TBL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_RD_CTE    = 3'd2,
    ST_CFG_HORA  = 3'd3,
    ST_CFG_FECHA = 3'd4,
    ST_CFG_TIMER = 3'd5,
    ST_WR_HF     = 3'd6,
    ST_WR_TMR    = 3'd7
  } state_e;

  // One RTC bus request as decoded from the step tables
  typedef struct packed {
    logic [TBL_W-1:0] addr;
    logic [TBL_W-1:0] data;
    logic             wr;
    logic             inicio;
    logic             en;
  } step_cmd_t;

  localparam state_e    ST_RESET  = ST_IDLE;
  localparam step_cmd_t CMD_RESET = '0;

  localparam int unsigned LEN_INIT      = 12;
  localparam int unsigned LEN_RD_CTE    = 11;
  localparam int unsigned LEN_CFG_HORA  = 4;
  localparam int unsigned LEN_CFG_FECHA = 8;
  localparam int unsigned LEN_CFG_TIMER = 8;
  localparam int unsigned LEN_WR_HF     = 8;
  localparam int unsigned LEN_WR_TMR    = 5;

  // Number of bus steps in each block; the terminal step index equals this value
  function automatic int unsigned seq_len(input state_e st);
    case (st)
      ST_INIT:      return LEN_INIT;
      ST_RD_CTE:    return LEN_RD_CTE;
      ST_CFG_HORA:  return LEN_CFG_HORA;
      ST_CFG_FECHA: return LEN_CFG_FECHA;
      ST_CFG_TIMER: return LEN_CFG_TIMER;
      ST_WR_HF:     return LEN_WR_HF;
      ST_WR_TMR:    return LEN_WR_TMR;
      default:      return 0;
    endcase
  endfunction

  // Step table lookup; terminal and out-of-range steps decode to an idle bus
  function automatic step_cmd_t step_cmd(input state_e st, input int unsigned idx);
    step_cmd_t c;
    c = CMD_RESET;
    if (idx < seq_len(st)) begin
      c.en = 1'b1;
      case (st)
        ST_INIT: begin
          c.wr     = 1'b1;
          c.inicio = 1'b1;
          case (idx)
            0:       begin c.addr = 8'h02; c.data = 8'h10; end
            1:       c.addr = 8'h02;
            2:       begin c.addr = 8'h10; c.data = 8'hD2; end
            3:       c.addr = 8'h00;
            11:      c.addr = 8'hF1;
            default: c.addr = 8'h1D + TBL_W'(idx);
          endcase
        end
        ST_RD_CTE: begin
          case (idx)
            0:         c.addr = 8'hF0;
            8, 9, 10:  c.addr = 8'h39 + TBL_W'(idx);
            default:   c.addr = 8'h20 + TBL_W'(idx);
          endcase
        end
        ST_CFG_HORA: c.addr = (idx == 0) ? 8'hF2 : 8'h40 + TBL_W'(idx);
        ST_CFG_FECHA: begin
          case (idx)
            0:        c.addr = 8'hF1;
            4:        c.addr = 8'hF2;
            5, 6, 7:  c.addr = 8'h3C + TBL_W'(idx);
            default:  c.addr = 8'h20 + TBL_W'(idx);
          endcase
        end
        ST_CFG_TIMER: c.addr = (idx == 0) ? 8'hF1 : 8'h20 + TBL_W'(idx);
        ST_WR_HF: begin
          c.wr   = 1'b1;
          c.addr = (idx == 7) ? 8'hF1 : 8'h21 + TBL_W'(idx);
        end
        ST_WR_TMR: begin
          c.wr = 1'b1;
          case (idx)
            3:       c.addr = 8'hF2;
            4:       begin c.addr = 8'h00; c.data = 8'h08; c.inicio = 1'b1; end
            default: c.addr = 8'h41 + TBL_W'(idx);
          endcase
        end
        default: c = CMD_RESET;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rtc_seq_engine_if.sv
// rtc_seq_engine_if: request/done bus between the sequencer and the RTC bus-interface block.
interface rtc_seq_engine_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          in_flag_done;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_flag_inicio;
  logic          out_wr;
  logic          out_en;

  modport master (
    input  in_flag_done,
    output out_addr, out_data, out_flag_inicio, out_wr, out_en
  );

  modport slave (
    output in_flag_done,
    input  out_addr, out_data, out_flag_inicio, out_wr, out_en
  );
endinterface

// File: rtl/rtc_cfg_sync.sv
// rtc_cfg_sync: multi-stage synchroniser for the three asynchronous config switches.
module rtc_cfg_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_count,
  input  logic [2:0] i_sel,
  output logic [2:0] o_sel
);
  logic [SYNC_STAGES-1:0][2:0] r_sync;

  // Shift the switch word through the synchroniser chain
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) r_sync <= '0;
    else             r_sync <= {r_sync[SYNC_STAGES-2:0], i_sel};
  end

  assign o_sel = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/rtc_seq_engine.sv
// rtc_seq_engine: table-driven RTC register-access sequencer.
// Optional per-step timeout/retry enabled by defining RTC_SEQ_TIMEOUT_EN.
module rtc_seq_engine
  import rtc_seq_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned STEP_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                reset_count,
  input  logic [2:0]          in_cfg_sel,
  output logic [2:0]          out_funcion_conf,
  output logic                out_busy,
  output logic [2:0]          out_block,
  output logic                out_err,
  rtc_seq_engine_if.master    bus
);

  state_e            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [2:0]        w_conf;
  step_cmd_t         w_cmd;
  int unsigned       w_idx, w_len;
  logic              w_tmo_hit;

  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data, r_data;
  logic          w_inicio, r_inicio;
  logic          w_wr, r_wr;
  logic          w_en, r_en;
  logic          w_busy, r_busy;
  logic [2:0]    w_block, r_block;
  logic          r_err;

  rtc_cfg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cfg_sync (
    .clk         (clk),
    .reset_count (reset_count),
    .i_sel       (in_cfg_sel),
    .o_sel       (w_conf)
  );

  assign w_idx = 32'(r_step);
  assign w_len = seq_len(r_state);
  assign w_cmd = step_cmd(r_state, w_idx);

  // State and step registers
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      r_state <= ST_RESET;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next state: block decision at the terminal step, step advance on accepted done
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (r_state == ST_IDLE) begin
      w_state_nxt = ST_INIT;
      w_step_nxt  = '0;
    end else if (w_idx > w_len) begin
      w_state_nxt = ST_IDLE;
      w_step_nxt  = '0;
    end else if (w_idx == w_len) begin
      w_step_nxt = '0;
      case (r_state)
        ST_INIT, ST_WR_HF, ST_WR_TMR: w_state_nxt = ST_RD_CTE;
        ST_RD_CTE: begin
          case (w_conf)
            3'b001:  w_state_nxt = ST_CFG_HORA;
            3'b010:  w_state_nxt = ST_CFG_FECHA;
            3'b100:  w_state_nxt = ST_CFG_TIMER;
            default: w_state_nxt = ST_RD_CTE;
          endcase
        end
        ST_CFG_HORA, ST_CFG_FECHA: w_state_nxt = (w_conf == 3'b000) ? ST_WR_HF : r_state;
        ST_CFG_TIMER:              w_state_nxt = (w_conf == 3'b000) ? ST_WR_TMR : r_state;
        default:                   w_state_nxt = ST_IDLE;
      endcase
    end else if (bus.in_flag_done && r_en) begin
      w_step_nxt = r_step + STEP_W'(1);
    end
  end

  // Output decode from current state and step
  always_comb begin
    w_addr   = AW'(w_cmd.addr);
    w_data   = DW'(w_cmd.data);
    w_inicio = w_cmd.inicio;
    w_wr     = w_cmd.wr;
    w_en     = w_cmd.en & ~w_tmo_hit;
    w_busy   = (r_state != ST_IDLE);
    w_block  = r_state;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_inicio <= 1'b0;
      r_wr     <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_block  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_inicio <= w_inicio;
      r_wr     <= w_wr;
      r_en     <= w_en;
      r_busy   <= w_busy;
      r_block  <= w_block;
      r_err    <= w_tmo_hit;
    end
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo_hit = w_cmd.en && (r_tmo == TMO_W'(TIMEOUT_CYC));

  // Per-step watchdog; restarts on any step/state change and after each reissue
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      r_tmo <= '0;
    end else if (!w_cmd.en || w_tmo_hit || (w_state_nxt != r_state) || (w_step_nxt != r_step)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  logic unused_tmo_cfg;
  assign w_tmo_hit      = 1'b0;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

  assign bus.out_addr        = r_addr;
  assign bus.out_data        = r_data;
  assign bus.out_flag_inicio = r_inicio;
  assign bus.out_wr          = r_wr;
  assign bus.out_en          = r_en;
  assign out_funcion_conf    = w_conf;
  assign out_busy            = r_busy;
  assign out_block           = r_block;
  assign out_err             = r_err;

endmodule
